wbs_uart: RTL and testbench

Wishbone B4 pipelined slave implementing an 8N1 UART transmitter with a TX FIFO and a programmable baud divisor, with an optional receiver. It sits directly downstream of the SPI-controlled Wishbone master: the MCU issues 8-bit-address register reads and writes over SPI, and this block turns them into serial traffic on `uart_tx`.

---
 rtl/wbs_uart_pkg.sv | 26 ++
 rtl/wbs_uart_fifo.sv | 47 ++++
 rtl/wbs_uart.sv | 272 +++++++++++++++++++++++++++
 tb/tb_wbs_uart.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbs_uart_pkg.sv
// Shared definitions for the Wishbone UART: register indices, STATUS bit
// positions, TX/RX state encodings and the divisor floor.
package wbs_uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  localparam int ST_TX_FULL  = 0;
  localparam int ST_TX_EMPTY = 1;
  localparam int ST_TX_BUSY  = 2;
  localparam int ST_RX_VALID = 3;
  localparam int ST_RX_OVR   = 4;
  localparam int ST_RX_FERR  = 5;

  localparam logic [15:0] DIV_MIN = 16'd2;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // Divisors below DIV_MIN cannot produce a sensible bit period.
  function automatic logic [15:0] eff_div(input logic [15:0] d);
    return (d < DIV_MIN) ? DIV_MIN : d;
  endfunction

endpackage

// File: rtl/wbs_uart_fifo.sv
// Synchronous FIFO with one extra pointer bit to tell full from empty.
// Push while full and pop while empty are ignored.
module wbs_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rptr[AW-1:0]];

  // Pointer update; each pointer wraps modulo 2*DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since empty gates the read side.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/wbs_uart.sv
// Wishbone B4 pipelined slave driving an 8N1 UART transmitter through a
// TX FIFO with a programmable baud divisor.
// Define WBS_UART_RX_EN to compile in the receiver.
// Bus handshake: a request is taken when cyc & stb & !stall; stall only
// rises for a DATA byte push into a full FIFO; ack is a registered pulse
// one cycle after acceptance, carrying read data in that same cycle.
module wbs_uart
  import wbs_uart_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd104
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [15:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_stall_o,
  output logic        wb_ack_o,
  output logic        uart_tx,
  input  logic        uart_rx
);

  logic        accept;
  logic        is_data;
  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic [7:0]  fifo_rdata;
  logic [15:0] div_q;
  logic [31:0] rd_word;

  tx_state_e   tx_state;
  logic [15:0] tx_cnt;
  logic [15:0] tx_div;
  logic [7:0]  tx_shift;
  logic [2:0]  tx_bit;
  logic        tx_bit_end;

  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        rx_overrun;
  logic        rx_ferr;

  logic        unused_bits;
  assign unused_bits = ^{wb_adr_i[15:2], wb_dat_i[31:16], wb_sel_i[3:2]};

  assign is_data    = (wb_adr_i[1:0] == REG_DATA);
  assign wb_stall_o = wb_cyc_i & wb_stb_i & wb_we_i & is_data & wb_sel_i[0] & full;
  assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;
  assign push       = accept & wb_we_i & is_data & wb_sel_i[0];
  assign pop        = (tx_state == TX_IDLE) & ~empty;
  assign tx_bit_end = (tx_cnt == tx_div - 16'd1);

  wbs_uart_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .push  (push),
    .wdata (wb_dat_i[7:0]),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (full),
    .empty (empty)
  );

  // Read mux; STATUS shows the state as it stands in the accept cycle.
  always_comb begin
    rd_word = '0;
    case (wb_adr_i[1:0])
      REG_DATA:   rd_word[7:0] = rx_byte;
      REG_STATUS: begin
        rd_word[ST_TX_FULL]  = full;
        rd_word[ST_TX_EMPTY] = empty;
        rd_word[ST_TX_BUSY]  = (tx_state != TX_IDLE);
        rd_word[ST_RX_VALID] = rx_valid;
        rd_word[ST_RX_OVR]   = rx_overrun;
        rd_word[ST_RX_FERR]  = rx_ferr;
      end
      REG_DIV:    rd_word[15:0] = div_q;
      default:    rd_word = '0;
    endcase
  end

  // Bus response and divisor register.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      div_q    <= DIV_RESET;
    end else begin
      wb_ack_o <= accept;
      wb_dat_o <= (accept & ~wb_we_i) ? rd_word : '0;
      if (accept & wb_we_i & (wb_adr_i[1:0] == REG_DIV)) begin
        if (wb_sel_i[0]) div_q[7:0]  <= wb_dat_i[7:0];
        if (wb_sel_i[1]) div_q[15:8] <= wb_dat_i[15:8];
      end
    end
  end

  // TX FSM; uart_tx is registered and the divisor is frozen for each frame.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      tx_state <= TX_IDLE;
      uart_tx  <= 1'b1;
      tx_cnt   <= '0;
      tx_div   <= DIV_MIN;
      tx_shift <= '0;
      tx_bit   <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          uart_tx <= 1'b1;
          if (!empty) begin
            tx_shift <= fifo_rdata;
            tx_div   <= eff_div(div_q);
            tx_cnt   <= '0;
            uart_tx  <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_bit_end) begin
            tx_cnt   <= '0;
            tx_bit   <= '0;
            uart_tx  <= tx_shift[0];
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        TX_DATA: begin
          if (tx_bit_end) begin
            tx_cnt <= '0;
            if (tx_bit == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= tx_shift >> 1;
              uart_tx  <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        TX_STOP: begin
          if (tx_bit_end) begin
            tx_cnt   <= '0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 16'd1;
          end
        end
        default: tx_state <= TX_IDLE;
      endcase
    end
  end

`ifdef WBS_UART_RX_EN
  rx_state_e   rx_state;
  logic        rx_s1;
  logic        rx_s2;
  logic        rx_prev;
  logic [15:0] rx_cnt;
  logic [15:0] rx_div;
  logic [7:0]  rx_shift;
  logic [2:0]  rx_bit;
  logic        rd_data_clr;
  logic        rd_status_clr;
  logic        rx_valid_eff;

  assign rd_data_clr   = accept & ~wb_we_i & is_data;
  assign rd_status_clr = accept & ~wb_we_i & (wb_adr_i[1:0] == REG_STATUS);
  // A byte landing in the same cycle as a DATA read is not an overrun.
  assign rx_valid_eff  = rx_valid & ~rd_data_clr;

  // Two-flop synchronizer plus one history flop for edge detection.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // RX FSM and flags; a new event in the same cycle as a clear wins.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_div     <= DIV_MIN;
      rx_shift   <= '0;
      rx_bit     <= '0;
      rx_byte    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      rx_ferr    <= 1'b0;
    end else begin
      if (rd_data_clr) rx_valid <= 1'b0;
      if (rd_status_clr) begin
        rx_overrun <= 1'b0;
        rx_ferr    <= 1'b0;
      end
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev & ~rx_s2) begin
            rx_div   <= eff_div(div_q);
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == (rx_div >> 1) - 16'd1) begin
            rx_cnt <= '0;
            rx_bit <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == rx_div - 16'd1) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_bit == 3'd7) rx_state <= RX_STOP;
            else                rx_bit   <= rx_bit + 3'd1;
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == rx_div - 16'd1) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (!rx_s2) begin
              rx_ferr <= 1'b1;
            end else if (rx_valid_eff) begin
              rx_overrun <= 1'b1;
            end else begin
              rx_byte  <= rx_shift;
              rx_valid <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 16'd1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end
`else
  logic unused_rx;
  assign unused_rx  = uart_rx;
  assign rx_byte    = '0;
  assign rx_valid   = 1'b0;
  assign rx_overrun = 1'b0;
  assign rx_ferr    = 1'b0;
`endif

endmodule

// File: tb/tb_wbs_uart.sv
// Directed bench for wbs_uart: bus register access, TX frame shape and
// timing, FIFO full/stall, divisor latching, async reset and (with
// WBS_UART_RX_EN) the receiver.
module tb_wbs_uart;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [15:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        stall, ack, tx, rx;

  int n_cmp = 0;
  int n_bad = 0;

  // expected frames: {divisor[15:0], byte[7:0]}
  logic [23:0] exp_q[$];
  logic        mon_busy = 1'b0;

  wbs_uart #(.FIFO_DEPTH(8), .DIV_RESET(16'd104)) dut (
    .wb_clk_i   (clk),
    .wb_rst_ni  (rst_n),
    .wb_cyc_i   (cyc),
    .wb_stb_i   (stb),
    .wb_we_i    (we),
    .wb_sel_i   (sel),
    .wb_adr_i   (adr),
    .wb_dat_i   (dat_w),
    .wb_dat_o   (dat_r),
    .wb_stall_o (stall),
    .wb_ack_o   (ack),
    .uart_tx    (tx),
    .uart_rx    (rx)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic wb_xfer(input logic w, input logic [1:0] a, input logic [31:0] d,
                         input logic [3:0] s, output logic [31:0] rdat, output int stalls);
    stalls = 0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = {14'd0, a}; dat_w = d; sel = s;
    #1;
    while (stall && stalls < 200) begin
      stalls++;
      @(negedge clk);
      #1;
    end
    if (stalls >= 200) check("stall_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    check("ack", {31'd0, ack}, 32'd1);
    rdat = dat_r;
    cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0;
  endtask

  task automatic wb_wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    int st;
    wb_xfer(1'b1, a, d, s, r, st);
  endtask

  task automatic wb_rd(input logic [1:0] a, output logic [31:0] r);
    int st;
    wb_xfer(1'b0, a, 32'd0, 4'hF, r, st);
  endtask

  task automatic push_byte(input logic [7:0] b, input logic [15:0] d);
    exp_q.push_back({d, b});
    wb_wr(2'd0, {24'd0, b}, 4'b0001);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check(tag, {31'd0, n < 5000}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b, input int d, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = f[i];
      repeat (d) @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  // ---------------- TX scoreboard monitor ----------------
  // Checks every cycle of each frame against the expected waveform,
  // plus the single idle cycle that must follow the stop bit.
  initial begin : monitor
    logic [23:0] ent;
    logic [7:0]  b, got;
    logic        e;
    int          d, errs, bitn, n;
    bit          aborted;
    forever begin
      @(negedge clk);
      if (rst_n && tx == 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame", 32'd1, 32'd0);
          n = 0;
          while (tx == 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
          end
        end else begin
          ent = exp_q.pop_front();
          mon_busy = 1'b1;
          d = int'(ent[23:8]);
          b = ent[7:0];
          errs = 0;
          got = '0;
          aborted = 1'b0;
          for (int i = 0; i < 10 * d; i++) begin
            if (!rst_n) begin
              aborted = 1'b1;
              break;
            end
            bitn = i / d;
            if (bitn == 0)      e = 1'b0;
            else if (bitn == 9) e = 1'b1;
            else                e = b[bitn-1];
            if (tx !== e) errs++;
            if (bitn >= 1 && bitn <= 8 && (i % d) == d / 2) got[bitn-1] = tx;
            @(negedge clk);
          end
          if (!aborted && rst_n) begin
            if (tx !== 1'b1) errs++;
            check("frame_byte", {24'd0, got}, {24'd0, b});
            check("frame_shape_errs", errs, 32'd0);
          end
          mon_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    logic [31:0] r;
    int st;

    rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    sel = 4'h0; adr = 16'h0; dat_w = 32'h0; rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_dat", dat_r, 32'd0);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // reset register values
    wb_rd(2'd1, r); check("rst_status", r, 32'h02);
    wb_rd(2'd2, r); check("rst_div", r, 32'd104);
    wb_rd(2'd3, r); check("reg3_read", r, 32'd0);

    // pipelined write then read: back-to-back acks
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 16'd2; dat_w = 32'h0000_0003; sel = 4'b0011;
    @(posedge clk); #1;
    check("burst_ack1", {31'd0, ack}, 32'd1);
    we = 1'b0; sel = 4'hF;
    @(posedge clk); #1;
    check("burst_ack2", {31'd0, ack}, 32'd1);
    check("burst_rd_div", dat_r, 32'd3);
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1;
    check("ack_drop", {31'd0, ack}, 32'd0);

    // DIV=4, DATA=0x55: exact frame and push-to-start latency
    wb_wr(2'd2, 32'd4, 4'b0011);
    push_byte(8'h55, 16'd4);
    check("tx_high_after_push", {31'd0, tx}, 32'd1);
    @(posedge clk); #1;
    check("tx_falls_n2", {31'd0, tx}, 32'd0);
    wb_rd(2'd1, r); check("status_busy", r, 32'h06);
    drain("drain_55");
    wb_rd(2'd1, r); check("status_idle", r, 32'h02);

    // ignored writes: DATA without sel[0], STATUS, register 3
    wb_wr(2'd0, 32'h0000_00AA, 4'b0010);
    wb_wr(2'd1, 32'hFFFF_FFFF, 4'hF);
    wb_wr(2'd3, 32'hFFFF_FFFF, 4'hF);
    repeat (4) @(posedge clk);
    #1;
    wb_rd(2'd1, r); check("status_after_ignored", r, 32'h02);
    wb_rd(2'd2, r); check("div_after_ignored", r, 32'd4);

    // byte-lane writes to DIV
    wb_wr(2'd2, 32'h0000_1234, 4'b0010);
    wb_rd(2'd2, r); check("div_hi_lane", r, 32'h1204);
    wb_wr(2'd2, 32'h0000_0000, 4'b0011);
    wb_rd(2'd2, r); check("div_zero", r, 32'd0);

    // DIV=0 clamps to 2 cycles per bit, 20-cycle frame
    push_byte(8'hFF, 16'd2);
    drain("drain_ff");

    // FIFO full: one byte in flight plus 8 queued, the 10th push stalls
    wb_wr(2'd2, 32'd4, 4'b0011);
    push_byte(8'h01, 16'd4);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i), 16'd4);
    wb_rd(2'd1, r); check("status_full", r, 32'h05);
    exp_q.push_back({16'd4, 8'h99});
    wb_xfer(1'b1, 2'd0, 32'h0000_0099, 4'b0001, r, st);
    check("stall_seen", {31'd0, st > 0}, 32'd1);
    check("stall_bounded", {31'd0, st <= 40}, 32'd1);
    drain("drain_full");

    // DIV change mid-frame: current frame keeps 4, next uses 10
    push_byte(8'hC3, 16'd4);
    push_byte(8'h5A, 16'd10);
    repeat (6) @(posedge clk);
    #1;
    wb_wr(2'd2, 32'd10, 4'b0011);
    drain("drain_divchg");

    // async reset during a data bit
    push_byte(8'h00, 16'd10);
    repeat (27) @(posedge clk);
    #1;
    check("tx_low_in_data", {31'd0, tx}, 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check("tx_async_reset", {31'd0, tx}, 32'd1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wb_rd(2'd1, r); check("status_after_reset", r, 32'h02);
    wb_rd(2'd2, r); check("div_after_reset", r, 32'd104);
    repeat (12) @(posedge clk);
    #1;
    check("tx_idle_after_reset", {31'd0, tx}, 32'd1);

`ifdef WBS_UART_RX_EN
    // receiver: good byte, overrun, then a framing error
    wb_wr(2'd2, 32'd8, 4'b0011);
    send_rx(8'hA3, 8, 1'b1);
    send_rx(8'h3C, 8, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    wb_rd(2'd0, r); check("rx_data", r, 32'hA3);
    wb_rd(2'd1, r); check("rx_overrun_set", r, 32'h12);
    wb_rd(2'd1, r); check("rx_overrun_clr", r, 32'h02);
    send_rx(8'h5A, 8, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    wb_rd(2'd1, r); check("rx_ferr_set", r, 32'h22);
    wb_rd(2'd1, r); check("rx_ferr_clr", r, 32'h02);
`else
    // no receiver: DATA reads 0 whatever the line does
    send_rx(8'h00, 4, 1'b1);
    repeat (8) @(posedge clk);
    #1;
    wb_rd(2'd0, r); check("data_read_no_rx", r, 32'd0);
    wb_rd(2'd1, r); check("status_no_rx", r, 32'h02);
`endif

    drain("drain_final");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
